// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that gives one requester at a time a complete SPI burst:
// slave-select setup, byte-by-byte handoff to a byte engine, then hold and release.
module spi_txn_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_SLAVES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst,
  input  logic [NUM_REQ-1:0]                    i_req,
  input  logic [NUM_REQ*$clog2(NUM_SLAVES)-1:0] i_req_slave,
  input  logic [NUM_REQ*4-1:0]                  i_req_len,
  input  logic [NUM_REQ*8-1:0]                  i_tx_byte,
  output logic [NUM_REQ-1:0]                    o_grant,
  output logic [NUM_REQ-1:0]                    o_tx_pop,
  output logic [7:0]                            o_rx_byte,
  output logic [NUM_REQ-1:0]                    o_rx_valid,
  output logic [NUM_REQ-1:0]                    o_done,
  output logic [NUM_REQ-1:0]                    o_err,
  output logic                                  o_spi_tx_ready,
  output logic [7:0]                            o_spi_tx_byte,
  input  logic                                  i_spi_busy,
  input  logic                                  i_spi_byte_ready,
  input  logic [7:0]                            i_spi_rx_byte,
  output logic [NUM_SLAVES-1:0]                 o_ss_n
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]  LP_NREQ   = (PW+1)'(NUM_REQ);
  localparam logic [7:0]   LP_GAP_LD = 8'(GAP_CYCLES - 1);
  localparam logic [15:0]  LP_WD_LD  = 16'(TIMEOUT - 1);

  // state | meaning
  // IDLE  | no owner, ss_n released, waiting for any request
  // SETUP | slave selected, counting GAP_CYCLES before first byte
  // LOAD  | waiting for the byte engine to go idle, then hand it a byte
  // WAIT  | byte in flight, watchdog running until byte_ready
  // HOLD  | last byte done (or timeout), counting GAP_CYCLES before release
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_ss_n;
  logic [NUM_REQ-1:0]    r_grant;
  logic [PW-1:0]         r_idx;
  logic [PW-1:0]         r_rr_ptr;
  logic [3:0]            r_len;
  logic [3:0]            r_byte_cnt;
  logic [7:0]            r_gap_cnt;
  logic [15:0]           r_wd_cnt;
  logic                  r_tx_ready;
  logic [7:0]            r_tx_byte;
  logic [NUM_REQ-1:0]    r_tx_pop;
  logic [7:0]            r_rx_byte;
  logic [NUM_REQ-1:0]    r_rx_valid;
  logic [NUM_REQ-1:0]    r_done;
  logic [NUM_REQ-1:0]    r_err;

  logic [SW-1:0]         w_slv_arr [NUM_REQ];
  logic [3:0]            w_len_arr [NUM_REQ];
  logic [7:0]            w_tx_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_slv_arr[g] = i_req_slave[g*SW +: SW];
    assign w_len_arr[g] = i_req_len[g*4 +: 4];
    assign w_tx_arr[g]  = i_tx_byte[g*8 +: 8];
  end

  // Rotate requests so bit 0 is the requester after the last owner.
  logic [2*NUM_REQ-1:0] w_req_rot;
  logic                 w_win_found;
  logic [PW-1:0]        w_win_off;
  logic [PW:0]          w_win_sum;
  logic [PW-1:0]        w_win_idx;
  logic [PW:0]          w_next_sum;
  logic [PW-1:0]        w_next_ptr;

  assign w_req_rot = {i_req, i_req} >> r_rr_ptr;

  always_comb begin
    w_win_found = 1'b0;
    w_win_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_win_found = 1'b1;
        w_win_off   = PW'(i);
      end
    end
  end

  assign w_win_sum  = {1'b0, r_rr_ptr} + {1'b0, w_win_off};
  assign w_win_idx  = (w_win_sum >= LP_NREQ) ? PW'(w_win_sum - LP_NREQ) : PW'(w_win_sum);
  assign w_next_sum = {1'b0, r_idx} + {{PW{1'b0}}, 1'b1};
  assign w_next_ptr = (w_next_sum >= LP_NREQ) ? '0 : PW'(w_next_sum);

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PW-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  function automatic logic [NUM_SLAVES-1:0] f_ss_sel(input logic [SW-1:0] slv);
    f_ss_sel      = '1;
    f_ss_sel[slv] = 1'b0;
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= ST_IDLE;
      r_ss_n     <= '1;
      r_grant    <= '0;
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_tx_ready <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_pop   <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= '0;
      r_done     <= '0;
      r_err      <= '0;
    end else begin
      r_tx_ready <= 1'b0;
      r_tx_pop   <= '0;
      r_rx_valid <= '0;
      r_done     <= '0;
      r_err      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_idx      <= w_win_idx;
            r_grant    <= f_onehot(w_win_idx);
            r_ss_n     <= f_ss_sel(w_slv_arr[w_win_idx]);
            r_len      <= w_len_arr[w_win_idx];
            r_byte_cnt <= '0;
            r_gap_cnt  <= LP_GAP_LD;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= ST_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        ST_LOAD: begin
          if (!i_spi_busy) begin
            r_tx_ready <= 1'b1;
            r_tx_byte  <= w_tx_arr[r_idx];
            r_tx_pop   <= r_grant;
            r_wd_cnt   <= LP_WD_LD;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A byte arriving on the watchdog's last cycle still counts.
          if (i_spi_byte_ready) begin
            r_rx_byte  <= i_spi_rx_byte;
            r_rx_valid <= r_grant;
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (r_byte_cnt == r_len) begin
              r_gap_cnt <= LP_GAP_LD;
              r_state   <= ST_HOLD;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (r_wd_cnt == 16'd0) begin
            r_err     <= r_grant;
            r_gap_cnt <= LP_GAP_LD;
            r_state   <= ST_HOLD;
          end else begin
            r_wd_cnt <= r_wd_cnt - 16'd1;
          end
        end
        ST_HOLD: begin
          if (r_gap_cnt == 8'd0) begin
            r_ss_n   <= '1;
            r_grant  <= '0;
            r_done   <= r_grant;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ss_n         = r_ss_n;
  assign o_grant        = r_grant;
  assign o_tx_pop       = r_tx_pop;
  assign o_rx_byte      = r_rx_byte;
  assign o_rx_valid     = r_rx_valid;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_spi_tx_ready = r_tx_ready;
  assign o_spi_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a small byte-engine model drives the SPI
// side, expected rx bytes go through a scoreboard queue.
module tb_spi_txn_arbiter;

  localparam int NREQ = 2;
  localparam int NSLV = 4;
  localparam int SW   = 2;
  localparam int GAP  = 2;
  localparam int TMO  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*SW-1:0]  req_slave;
  logic [NREQ*4-1:0]   req_len;
  logic [NREQ*8-1:0]   tx_byte;
  logic [NREQ-1:0]     grant, tx_pop, rx_valid, done, err;
  logic [7:0]          rx_byte, spi_tx_byte, spi_rx_byte;
  logic                spi_tx_ready, spi_busy, spi_byte_ready;
  logic [NSLV-1:0]     ss_n;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .NUM_REQ(NREQ), .NUM_SLAVES(NSLV), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_req(req), .i_req_slave(req_slave),
    .i_req_len(req_len), .i_tx_byte(tx_byte), .o_grant(grant), .o_tx_pop(tx_pop),
    .o_rx_byte(rx_byte), .o_rx_valid(rx_valid), .o_done(done), .o_err(err),
    .o_spi_tx_ready(spi_tx_ready), .o_spi_tx_byte(spi_tx_byte),
    .i_spi_busy(spi_busy), .i_spi_byte_ready(spi_byte_ready),
    .i_spi_rx_byte(spi_rx_byte), .o_ss_n(ss_n)
  );

  typedef struct { int r; logic [7:0] d; } rx_exp_t;
  rx_exp_t rxq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] tx_cur [NREQ];
  bit         eng_respond, eng_spur;
  int         eng_busy_pre, busy_cnt, resp_cnt;
  logic [7:0] eng_rx_next;

  int cur_r, cur_slave;
  bit mon_on;
  int n_tx, n_rx, n_done, n_err, t_grant, t_tx1, t_rx_last, t_done, t_err;
  bit ss_bad, busy_bad, pop_bad;
  logic [NREQ-1:0] grant_first, done_vec, err_vec, grant_at_done;
  logic [NSLV-1:0] ss_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int r);
    oh    = '0;
    oh[r] = 1'b1;
  endfunction

  function automatic logic [NSLV-1:0] exp_ss(input int s);
    exp_ss    = '1;
    exp_ss[s] = 1'b0;
  endfunction

  task automatic drive_tx();
    for (int r = 0; r < NREQ; r++) tx_byte[r*8 +: 8] = tx_cur[r];
  endtask

  task automatic set_cfg(input int r, input int slv, input int nbytes);
    req_slave[r*SW +: SW] = SW'(slv);
    req_len[r*4 +: 4]     = 4'(nbytes - 1);
  endtask

  task automatic mon_clear();
    n_tx = 0; n_rx = 0; n_done = 0; n_err = 0;
    t_grant = -1; t_tx1 = -1; t_rx_last = -1; t_done = -1; t_err = -1;
    ss_bad = 0; busy_bad = 0; pop_bad = 0;
    grant_first = '0; done_vec = '0; err_vec = '0;
    grant_at_done = '0; ss_at_done = '0;
    mon_on = 1;
  endtask

  // One clock: sample DUT 1 ns after the edge, then model the byte engine.
  task automatic tick();
    logic    prev_busy;
    rx_exp_t e;
    prev_busy = spi_busy;
    @(posedge clk);
    #1;
    cyc++;
    chk("onehot0", 32'({$onehot0(grant), $onehot0(tx_pop), $onehot0(rx_valid),
                        $onehot0(done), $onehot0(err), $onehot0(~ss_n)}), 32'h3F);
    if (mon_on && grant != '0) begin
      if (t_grant < 0) begin
        t_grant     = cyc;
        grant_first = grant;
      end
      if (ss_n !== exp_ss(cur_slave)) ss_bad = 1'b1;
    end
    if (tx_pop != '0 && !spi_tx_ready) pop_bad = 1'b1;
    if (spi_tx_ready) begin
      n_tx++;
      if (n_tx == 1) t_tx1 = cyc;
      if (prev_busy !== 1'b0) busy_bad = 1'b1;
      chk("tx_byte", 32'(spi_tx_byte), 32'(tx_cur[cur_r]));
      chk("tx_pop", 32'(tx_pop), 32'(oh(cur_r)));
      tx_cur[cur_r] = tx_cur[cur_r] + 8'h11;
      resp_cnt = 2;
    end
    if (rx_valid != '0) begin
      n_rx++;
      t_rx_last = cyc;
      if (rxq.size() == 0) begin
        chk("rx_unexpected", 32'(rx_valid), 32'h0);
      end else begin
        e = rxq.pop_front();
        chk("rx_valid", 32'(rx_valid), 32'(oh(e.r)));
        chk("rx_byte", 32'(rx_byte), 32'(e.d));
      end
    end
    if (done != '0) begin
      n_done++; done_vec = done; t_done = cyc;
      ss_at_done = ss_n; grant_at_done = grant;
    end
    if (err != '0) begin
      n_err++; err_vec = err; t_err = cyc;
    end
    spi_byte_ready = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) spi_busy = 1'b0;
      else if (eng_spur) begin
        spi_byte_ready = 1'b1;
        spi_rx_byte    = 8'hEE;
      end
    end
    if (!spi_tx_ready && resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && eng_respond) begin
        spi_byte_ready = 1'b1;
        spi_rx_byte    = eng_rx_next;
        rxq.push_back('{r: cur_r, d: eng_rx_next});
        eng_rx_next = eng_rx_next + 8'h07;
        if (eng_busy_pre > 0) begin
          spi_busy = 1'b1;
          busy_cnt = eng_busy_pre;
        end
      end
    end
    drive_tx();
  endtask

  task automatic burst(input int r, input int slv, input int nbytes, input bit exp_err,
                       input bit mutate, input bit drop_after, input string tag);
    int budget;
    cur_r = r;
    cur_slave = slv;
    mon_clear();
    resp_cnt = 0;
    busy_cnt = eng_busy_pre;
    spi_busy = (eng_busy_pre > 0);
    budget = 0;
    while (n_done == 0 && budget < 2000) begin
      tick();
      budget++;
      if (mutate && grant != '0) begin
        req = '0; req_slave = '0; req_len = '0;
      end
    end
    chk({tag, "_done_seen"}, 32'(n_done), 32'd1);
    chk({tag, "_grant"}, 32'(grant_first), 32'(oh(r)));
    chk({tag, "_ss_n_burst"}, 32'(ss_bad), 32'd0);
    chk({tag, "_n_tx"}, 32'(n_tx), exp_err ? 32'd1 : 32'(nbytes));
    chk({tag, "_n_rx"}, 32'(n_rx), exp_err ? 32'd0 : 32'(nbytes));
    chk({tag, "_done_vec"}, 32'(done_vec), 32'(oh(r)));
    chk({tag, "_n_err"}, 32'(n_err), 32'(exp_err));
    if (exp_err) chk({tag, "_err_vec"}, 32'(err_vec), 32'(oh(r)));
    chk({tag, "_ss_n_release"}, 32'(ss_at_done), 32'hF);
    chk({tag, "_grant_release"}, 32'(grant_at_done), 32'd0);
    chk({tag, "_tx_while_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_stray_pop"}, 32'(pop_bad), 32'd0);
    chk({tag, "_rxq_empty"}, 32'(rxq.size()), 32'd0);
    if (eng_busy_pre == 0) chk({tag, "_setup_len"}, 32'(t_tx1 - t_grant), 32'(GAP + 1));
    if (exp_err) begin
      chk({tag, "_wd_len"}, 32'(t_err - t_tx1), 32'(TMO));
      chk({tag, "_hold_len"}, 32'(t_done - t_err), 32'(GAP));
    end else begin
      chk({tag, "_hold_len"}, 32'(t_done - t_rx_last), 32'(GAP));
    end
    if (drop_after) req = '0;
  endtask

  initial begin
    int budget;
    rst = 1'b1; req = '0; req_slave = '0; req_len = '0;
    spi_busy = 1'b0; spi_byte_ready = 1'b0; spi_rx_byte = '0;
    tx_cur[0] = 8'h10; tx_cur[1] = 8'h80; drive_tx();
    eng_respond = 1; eng_spur = 0; eng_busy_pre = 0; busy_cnt = 0; resp_cnt = 0;
    eng_rx_next = 8'h40; cur_r = 0; cur_slave = 0; mon_on = 0;

    repeat (3) tick();
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_ready", 32'(spi_tx_ready), 32'd0);
    chk("rst_outs", 32'({tx_pop, rx_valid, done, err}), 32'd0);
    rst = 1'b0;

    // Both requesting: owners alternate starting at requester 0.
    set_cfg(0, 2, 2);
    set_cfg(1, 1, 1);
    req = 2'b11;
    burst(0, 2, 2, 0, 0, 0, "alt0");
    burst(1, 1, 1, 0, 0, 0, "alt1");
    burst(0, 2, 2, 0, 0, 0, "alt2");
    burst(1, 1, 1, 0, 0, 1, "alt3");

    // Single byte A5 out, 3C back, slave 2.
    set_cfg(0, 2, 1);
    tx_cur[0] = 8'hA5; drive_tx();
    eng_rx_next = 8'h3C;
    req = 2'b01;
    burst(0, 2, 1, 0, 0, 1, "single");

    // Request config changed and request dropped mid-burst.
    set_cfg(0, 3, 3);
    req = 2'b01;
    burst(0, 3, 3, 0, 1, 1, "mutate");

    // byte_ready while idle, then during setup/load/hold of a burst.
    set_cfg(1, 1, 3);
    eng_spur = 1; spi_busy = 1'b1; busy_cnt = 4;
    repeat (4) tick();
    chk("spur_idle_grant", 32'(grant), 32'd0);
    eng_busy_pre = 3;
    req = 2'b10;
    burst(1, 1, 3, 0, 0, 1, "spur");
    eng_spur = 0; eng_busy_pre = 0;

    // 16 bytes with busy held high before every byte.
    set_cfg(0, 2, 16);
    eng_busy_pre = 5;
    req = 2'b01;
    burst(0, 2, 16, 0, 0, 1, "len16");
    eng_busy_pre = 0;

    // Engine never answers: watchdog error, remaining bytes skipped.
    set_cfg(1, 1, 4);
    eng_respond = 0;
    req = 2'b10;
    burst(1, 1, 4, 1, 0, 1, "timeout");
    eng_respond = 1;

    // Leave the pointer at requester 1, then abort a burst of requester 1.
    set_cfg(0, 0, 1);
    req = 2'b01;
    burst(0, 0, 1, 0, 0, 1, "pre_rst");
    set_cfg(1, 1, 8);
    cur_r = 1; cur_slave = 1;
    mon_clear();
    resp_cnt = 0; busy_cnt = 0; spi_busy = 1'b0;
    req = 2'b11;
    budget = 0;
    while (n_tx < 3 && budget < 500) begin
      tick();
      budget++;
    end
    chk("abort_reach_byte3", 32'(n_tx), 32'd3);
    chk("abort_grant", 32'(grant_first), 32'(oh(1)));
    rst = 1'b1;
    resp_cnt = 0;
    tick();
    rst = 1'b0;
    chk("abort_ss_n", 32'(ss_n), 32'hF);
    chk("abort_grant_clr", 32'(grant), 32'd0);
    chk("abort_done_err", 32'({done, err}), 32'd0);
    chk("abort_no_done_seen", 32'(n_done + n_err), 32'd0);
    chk("abort_rxq_empty", 32'(rxq.size()), 32'd0);
    burst(0, 0, 1, 0, 0, 1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
